// File: rtl/keypad_scan_ctrl.sv
// ROWSxCOLS matrix-keypad scanner: prescaled tick, N-sample debounce, press/release/repeat pulses.
// Latency: 2 clk row sync, then DEBOUNCE ticks to accept; no backpressure (event pulses are not held).
module keypad_scan_ctrl #(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int TICK_DIV    = 2**20,
    parameter int DEBOUNCE    = 3,
    parameter int REPEAT_DLY  = 25,
    parameter int REPEAT_RATE = 5,
    localparam int CODE_W     = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    input  logic              repeat_en,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_release,
    output logic              key_down,
    output logic              multi_key
);

    localparam int TW   = $clog2(TICK_DIV);
    localparam int IW   = $clog2(COLS);
    localparam int RIW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW   = $clog2(DEBOUNCE + 1);
    localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int RW   = (RMAX > 0) ? $clog2(RMAX + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    state_t            state;
    logic [TW-1:0]     tcnt;
    logic              tick;
    logic [ROWS-1:0]   rs_meta;
    logic [ROWS-1:0]   rs;
    logic              all_hi;
    logic [IW-1:0]     idx;
    logic [ROWS-1:0]   pat;
    logic [DW-1:0]     cnt;
    logic [DW-1:0]     cnt_inc;
    logic              deb_done;
    logic [RW-1:0]     rc;
    logic [RW-1:0]     rc_inc;
    logic [RW-1:0]     rep_target;
    logic              rep_first;
    logic [ROWS-1:0]   acc_pat;
    logic [RIW-1:0]    low_row;
    int unsigned       n_low;
    logic [CODE_W-1:0] acc_code;

    assign tick = (tcnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    // Rows idle high through the pull-ups, so the synchroniser resets to all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_meta <= '1;
            rs      <= '1;
        end else begin
            rs_meta <= row;
            rs      <= rs_meta;
        end
    end

    assign all_hi     = &rs;
    assign cnt_inc    = cnt + DW'(1);
    assign deb_done   = (cnt_inc >= DW'(DEBOUNCE));
    assign rc_inc     = (rc == '1) ? rc : rc + RW'(1);
    assign rep_target = rep_first ? RW'(REPEAT_DLY) : RW'(REPEAT_RATE);

    // With DEBOUNCE==1 the press is accepted on the SCAN hit tick, before pat is loaded.
    assign acc_pat = (state == ST_SCAN) ? rs : pat;

    always_comb begin
        low_row = '0;
        n_low   = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!acc_pat[r]) begin
                low_row = RIW'(r);
                n_low   = n_low + 1;
            end
        end
    end

    assign acc_code = CODE_W'(int'(idx) * ROWS + int'(low_row));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            col         <= '0;
            idx         <= '0;
            pat         <= '1;
            cnt         <= '0;
            rc          <= '0;
            rep_first   <= 1'b1;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            key_down    <= 1'b0;
            multi_key   <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (!all_hi) begin
                            state <= ST_SCAN;
                            idx   <= '0;
                            col   <= ~COLS'(1);
                        end
                    end
                    ST_SCAN: begin
                        if (!all_hi) begin
                            pat <= rs;
                            cnt <= DW'(1);
                            if (DEBOUNCE == 1) begin
                                state     <= ST_PRESSED;
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                                key_code  <= acc_code;
                                multi_key <= (n_low > 1);
                                rc        <= '0;
                                rep_first <= 1'b1;
                            end else begin
                                state <= ST_DEBOUNCE;
                            end
                        end else if (idx == IW'(COLS - 1)) begin
                            state <= ST_IDLE;
                            col   <= '0;
                        end else begin
                            idx <= idx + IW'(1);
                            col <= ~(COLS'(1) << (idx + IW'(1)));
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (rs == pat) begin
                            if (deb_done) begin
                                state     <= ST_PRESSED;
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                                key_code  <= acc_code;
                                multi_key <= (n_low > 1);
                                rc        <= '0;
                                rep_first <= 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= ST_IDLE;
                            col   <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (all_hi) begin
                            cnt <= DW'(1);
                            if (DEBOUNCE == 1) begin
                                state       <= ST_IDLE;
                                key_release <= 1'b1;
                                key_down    <= 1'b0;
                                col         <= '0;
                            end else begin
                                state <= ST_RELEASE;
                            end
                        end else if (!repeat_en) begin
                            rc <= '0;
                        end else if (rc_inc >= rep_target) begin
                            key_valid <= 1'b1;
                            rc        <= '0;
                            rep_first <= 1'b0;
                        end else begin
                            rc <= rc_inc;
                        end
                    end
                    ST_RELEASE: begin
                        if (all_hi) begin
                            if (deb_done) begin
                                state       <= ST_IDLE;
                                key_release <= 1'b1;
                                key_down    <= 1'b0;
                                col         <= '0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            // Release bounce: resume the held key, repeat timing continues.
                            state <= ST_PRESSED;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        col   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix model driven by the column outputs,
// event timing predicted in ticks from the scan/debounce/repeat rules.
module tb_keypad_scan_ctrl;

    localparam int DEB  = 3;
    localparam int DLY  = 6;
    localparam int RATE = 2;

    typedef struct {
        int         tick;
        bit         rel;
        logic [3:0] code;
        bit         multi;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        repeat_en;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_release;
    logic        key_down;
    logic        multi_key;

    logic [15:0] keyset;
    int          cyc;
    int          checks = 0;
    int          errors = 0;
    ev_t         evq[$];

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .ROWS(4), .COLS(4), .TICK_DIV(4), .DEBOUNCE(DEB),
        .REPEAT_DLY(DLY), .REPEAT_RATE(RATE)
    ) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .repeat_en(repeat_en),
        .key_code(key_code), .key_valid(key_valid), .key_release(key_release),
        .key_down(key_down), .multi_key(multi_key)
    );

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col[c]) row = row & ~keyset[c*4 +: 4];
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid) begin
                ev_t e;
                e.tick = cyc / 4; e.rel = 1'b0; e.code = key_code; e.multi = multi_key;
                evq.push_back(e);
            end
            if (key_release) begin
                ev_t e;
                e.tick = cyc / 4; e.rel = 1'b1; e.code = key_code; e.multi = multi_key;
                evq.push_back(e);
            end
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do begin
                @(posedge clk);
                #1;
            end while (cyc % 4 != 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; keyset = '0; repeat_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (col !== 4'h0 || key_valid !== 1'b0 || key_release !== 1'b0 || key_down !== 1'b0
            || multi_key !== 1'b0 || key_code !== 4'h0) begin
            errors++;
            $display("FAIL reset_init: col=%h kv=%b kr=%b kd=%b mk=%b code=%0d, need col=0 all 0",
                     col, key_valid, key_release, key_down, multi_key, key_code);
        end
        @(negedge clk); rst = 1'b0;
        wait_ticks(1);
        keyset = 16'h0080;
        wait_ticks(3);
        checks++;
        if (col !== 4'b1101) begin
            errors++;
            $display("FAIL reset_mid_debounce_col: col=%b need 1101", col);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (col !== 4'h0 || key_valid !== 1'b0 || key_release !== 1'b0 || key_down !== 1'b0
            || multi_key !== 1'b0 || key_code !== 4'h0) begin
            errors++;
            $display("FAIL reset_abort: col=%h kv=%b kr=%b kd=%b mk=%b code=%0d, need all 0",
                     col, key_valid, key_release, key_down, multi_key, key_code);
        end
        keyset = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        evq.delete();
        wait_ticks(12);
        checks++;
        if (evq.size() != 0) begin
            errors++;
            $display("FAIL reset_no_event: %0d events after reset, need 0", evq.size());
        end
    endtask

    // Stable press held from the current tick for 'hold' ticks, then released.
    task automatic run_press(input string name, input logic [15:0] ks, input int hold, input bit rep);
        ev_t        exp_q[$];
        ev_t        e;
        int         t0, cmin, acc, rel, lowr, npop, n;
        logic [3:0] pat;
        logic [3:0] ecode;
        bit         emulti;
        cmin = 0;
        for (int c = 3; c >= 0; c--) if (ks[c*4 +: 4] != 4'h0) cmin = c;
        pat  = ks[cmin*4 +: 4];
        lowr = 0; npop = 0;
        for (int r = 3; r >= 0; r--) if (pat[r]) begin lowr = r; npop++; end
        ecode  = 4'(cmin * 4 + lowr);
        emulti = (npop > 1);
        evq.delete();
        t0 = cyc / 4;
        repeat_en = rep;
        keyset = ks;
        acc = t0 + 2 + cmin + DEB - 1;
        rel = t0 + hold;
        e.tick = acc; e.rel = 1'b0; e.code = ecode; e.multi = emulti;
        exp_q.push_back(e);
        if (rep) begin
            for (int t = acc + DLY; t <= rel; t += RATE) begin
                e.tick = t;
                exp_q.push_back(e);
            end
        end
        e.tick = rel + DEB; e.rel = 1'b1;
        exp_q.push_back(e);

        wait_ticks(acc + 1 - t0);
        checks++;
        if (key_down !== 1'b1 || key_code !== ecode || multi_key !== emulti) begin
            errors++;
            $display("FAIL %s held: kd=%b code=%0d mk=%b, need kd=1 code=%0d mk=%b",
                     name, key_down, key_code, multi_key, ecode, emulti);
        end
        wait_ticks(rel - cyc / 4);
        keyset = '0;
        wait_ticks(DEB + 2);
        checks++;
        if (key_down !== 1'b0 || col !== 4'h0) begin
            errors++;
            $display("FAIL %s after_release: kd=%b col=%h, need kd=0 col=0", name, key_down, col);
        end
        checks++;
        if (evq.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s event_count: got %0d, need %0d", name, evq.size(), exp_q.size());
        end
        n = (evq.size() < exp_q.size()) ? evq.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (evq[i].tick != exp_q[i].tick || evq[i].rel != exp_q[i].rel
                || evq[i].code !== exp_q[i].code || evq[i].multi != exp_q[i].multi) begin
                errors++;
                $display("FAIL %s event%0d: got tick=%0d rel=%b code=%0d mk=%b, need tick=%0d rel=%b code=%0d mk=%b",
                         name, i, evq[i].tick, evq[i].rel, evq[i].code, evq[i].multi,
                         exp_q[i].tick, exp_q[i].rel, exp_q[i].code, exp_q[i].multi);
            end
        end
    endtask

    task automatic test_single_press();
        run_press("single_c2r1", 16'h0200, 40, 1'b0);
    endtask

    task automatic test_auto_repeat();
        run_press("repeat_c0r0", 16'h0001, 15, 1'b1);
    endtask

    task automatic test_bounce();
        int t0;
        evq.delete();
        repeat_en = 1'b0;
        t0 = cyc / 4;
        for (int i = 0; i < 4; i++) begin
            keyset = (i % 2 == 0) ? 16'h0004 : 16'h0000;
            wait_ticks(1);
        end
        keyset = 16'h0004;
        wait_ticks(16);
        keyset = '0;
        wait_ticks(DEB + 2);
        checks++;
        if (evq.size() != 2) begin
            errors++;
            $display("FAIL bounce_count: got %0d events, need 2", evq.size());
        end else begin
            checks++;
            if (evq[0].rel != 1'b0 || evq[0].code !== 4'd2 || evq[0].tick <= t0 + 4 || evq[1].rel != 1'b1) begin
                errors++;
                $display("FAIL bounce_events: ev0 tick=%0d rel=%b code=%0d ev1 rel=%b, need press code=2 after tick %0d then release",
                         evq[0].tick, evq[0].rel, evq[0].code, evq[1].rel, t0 + 4);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] exp_col [5];
        exp_col[0] = 4'b1110; exp_col[1] = 4'b1101; exp_col[2] = 4'b1011;
        exp_col[3] = 4'b0111; exp_col[4] = 4'b0000;
        evq.delete();
        keyset = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            wait_ticks(1);
            keyset = '0;
            checks++;
            if (col !== exp_col[i]) begin
                errors++;
                $display("FAIL glitch_col%0d: col=%b need %b", i, col, exp_col[i]);
            end
        end
        wait_ticks(3);
        checks++;
        if (evq.size() != 0 || key_down !== 1'b0) begin
            errors++;
            $display("FAIL glitch_no_event: %0d events kd=%b, need 0 events kd=0", evq.size(), key_down);
        end
    endtask

    task automatic test_multi_key();
        int t0, acc;
        evq.delete();
        repeat_en = 1'b0;
        t0 = cyc / 4;
        keyset = 16'h5000;
        acc = t0 + 2 + 3 + DEB - 1;
        wait_ticks(acc + 1 - t0);
        checks++;
        if (key_code !== 4'd12 || multi_key !== 1'b1 || key_down !== 1'b1) begin
            errors++;
            $display("FAIL multi_accept: code=%0d mk=%b kd=%b, need code=12 mk=1 kd=1",
                     key_code, multi_key, key_down);
        end
        wait_ticks(1);
        keyset = '0;
        wait_ticks(1);
        keyset = 16'h5000;
        wait_ticks(3);
        checks++;
        if (key_down !== 1'b1 || evq.size() != 1) begin
            errors++;
            $display("FAIL multi_release_bounce: kd=%b events=%0d, need kd=1 events=1", key_down, evq.size());
        end
        keyset = '0;
        wait_ticks(DEB + 2);
        checks++;
        if (evq.size() != 2 || key_down !== 1'b0) begin
            errors++;
            $display("FAIL multi_release: events=%0d kd=%b, need 2 events kd=0", evq.size(), key_down);
        end else begin
            checks++;
            if (evq[1].rel != 1'b1 || evq[1].tick != acc + 6 + DEB) begin
                errors++;
                $display("FAIL multi_release_tick: rel=%b tick=%0d, need release at tick %0d",
                         evq[1].rel, evq[1].tick, acc + 6 + DEB);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ks;
        int          c;
        for (int it = 0; it < 12; it++) begin
            c  = $urandom_range(0, 3);
            ks = 16'(16'($urandom_range(1, 15)) << (c * 4));
            if ($urandom_range(0, 1) == 1) ks[$urandom_range(0, 15)] = 1'b1;
            run_press($sformatf("rand%0d", it), ks, $urandom_range(9, 30), 1'($urandom_range(0, 1)));
            wait_ticks(2);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_glitch();
        test_auto_repeat();
        test_multi_key();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
